// File: rtl/addition_subtraction_if.sv
// addition_subtraction_if: operand/result bundle for the binary32 adder/subtractor
interface addition_subtraction_if;
  logic in_valid;
  logic [31:0] a_operand;
  logic [31:0] b_operand;
  logic AddBar_Sub;
  logic out_valid;
  logic Exception;
  logic [31:0] result;
  modport master (output in_valid, a_operand, b_operand, AddBar_Sub, input out_valid, Exception, result);
  modport slave (input in_valid, a_operand, b_operand, AddBar_Sub, output out_valid, Exception, result);
endinterface

// File: rtl/addition_subtraction.sv
// addition_subtraction: single-cycle binary32 a +/- b, flush-to-zero, truncating, registered output
module addition_subtraction (
  input logic clk,
  input logic reset,
  addition_subtraction_if.slave bus
);
  logic [7:0] ea, eb, el, es, d;
  logic [30:0] ma, mb;
  logic sa, sb, sl, swap, same, zero, exc, under;
  logic [23:0] ml, ms, ss, diff, mant;
  logic [24:0] sum;
  logic [4:0] lz;
  logic [9:0] ne;
  logic [31:0] res;
  always_comb begin
    ea = bus.a_operand[30:23];
    eb = bus.b_operand[30:23];
    ma = ea == 8'd0 ? '0 : bus.a_operand[30:0];
    mb = eb == 8'd0 ? '0 : bus.b_operand[30:0];
    sa = bus.a_operand[31];
    sb = bus.b_operand[31] ^ bus.AddBar_Sub;
    swap = mb > ma;
    el = swap ? mb[30:23] : ma[30:23];
    es = swap ? ma[30:23] : mb[30:23];
    ml = el == 8'd0 ? '0 : {1'b1, swap ? mb[22:0] : ma[22:0]};
    ms = es == 8'd0 ? '0 : {1'b1, swap ? ma[22:0] : mb[22:0]};
    sl = swap ? sb : sa;
    d = el - es;
    ss = d >= 8'd24 ? '0 : ms >> d;
    same = sa == sb;
    sum = {1'b0, ml} + {1'b0, ss};
    diff = ml - ss;
    lz = 5'd24;
    for (int i = 0; i < 24; i++) if (diff[i]) lz = 5'(23 - i);
    mant = same ? (sum[24] ? sum[24:1] : sum[23:0]) : diff << lz;
    // ne is signed: a large left normalization can drive it below zero
    ne = same ? {2'b0, el} + {9'b0, sum[24]} : {2'b0, el} - {5'b0, lz};
    zero = same ? sum == 25'd0 : diff == 24'd0;
    exc = ea == 8'hFF || eb == 8'hFF || (!ne[9] && ne >= 10'd255);
    under = ne[9] || ne == 10'd0;
    res = (exc || zero || under) ? '0 : {sl, ne[7:0], mant[22:0]};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out_valid <= 1'b0;
      bus.Exception <= 1'b0;
      bus.result <= '0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.Exception <= exc;
        bus.result <= res;
      end
    end
  end
endmodule

// File: tb/tb_addition_subtraction.sv
// tb_addition_subtraction: directed and randomized checks against an arithmetic reference model
module tb_addition_subtraction;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_r = '0;
  logic exp_e = 1'b0;
  logic exp_v = 1'b0;
  addition_subtraction_if bus ();
  addition_subtraction dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Value-level model: align, add/subtract integer significands, then renormalize by loops
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic sub,
                                output logic [31:0] r, output logic e);
    int ea, eb, el, es, sh, ex;
    longint ma, mb, ka, kb, ml, ms, m;
    logic sa, sb, sl;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    r = '0;
    e = 1'b0;
    if (ea == 255 || eb == 255) begin
      e = 1'b1;
      return;
    end
    if (ea == 0) ma = 0; else ma = longint'({1'b1, a[22:0]});
    if (eb == 0) mb = 0; else mb = longint'({1'b1, b[22:0]});
    ka = longint'(ea) * 64'd16777216 + ma;
    kb = longint'(eb) * 64'd16777216 + mb;
    if (ma == 0) ka = 0;
    if (mb == 0) kb = 0;
    sa = a[31];
    sb = b[31] ^ sub;
    if (kb > ka) begin
      el = eb; es = ea; ml = mb; ms = ma; sl = sb;
    end else begin
      el = ea; es = eb; ml = ma; ms = mb; sl = sa;
    end
    sh = el - es;
    ms = sh >= 24 ? 0 : ms / (64'd1 << sh);
    m = (sa == sb) ? ml + ms : ml - ms;
    if (m == 0) return;
    ex = el;
    while (m >= 64'd16777216) begin
      m = m / 2;
      ex++;
    end
    while (m < 64'd8388608) begin
      m = m * 2;
      ex--;
    end
    if (ex >= 255) e = 1'b1;
    else if (ex > 0) r = {sl, ex[7:0], m[22:0]};
  endfunction

  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b, input logic s,
                      input logic r);
    @(negedge clk);
    reset = r;
    bus.in_valid = v;
    bus.a_operand = a;
    bus.b_operand = b;
    bus.AddBar_Sub = s;
    @(posedge clk);
    #1;
    if (r) begin
      exp_v = 1'b0;
      exp_r = '0;
      exp_e = 1'b0;
    end else begin
      exp_v = v;
      if (v) model(a, b, s, exp_r, exp_e);
    end
    chk("out_valid", 32'(bus.out_valid), 32'(exp_v));
    chk("result", bus.result, exp_r);
    chk("Exception", 32'(bus.Exception), 32'(exp_e));
  endtask

  logic [31:0] da [12] = '{32'h42006B85, 32'h3F800000, 32'h40400000, 32'h3F800000, 32'h3F800000,
                           32'h00000000, 32'h00000001, 32'h7F800000, 32'h7F7FFFFF, 32'h4B800000,
                           32'h4B000000, 32'h40000000};
  logic [31:0] db [12] = '{32'h41806B85, 32'h3F800000, 32'h3F800000, 32'h40000000, 32'h3F800000,
                           32'h80000000, 32'h3F800000, 32'h3F800000, 32'h7F7FFFFF, 32'h3F800000,
                           32'h3F800000, 32'h00000000};
  logic ds [12] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [31:0] dr [12] = '{32'h4240A147, 32'h40000000, 32'h40000000, 32'hBF800000, 32'h00000000,
                           32'h00000000, 32'h3F800000, 32'h00000000, 32'h00000000, 32'h4B800000,
                           32'h4B000001, 32'h40000000};
  logic de [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    bus.in_valid = 1'b0;
    bus.a_operand = '0;
    bus.b_operand = '0;
    bus.AddBar_Sub = 1'b0;
    step(1'b1, 32'h3F800000, 32'h3F800000, 1'b0, 1'b1);
    step(1'b1, 32'h3F800000, 32'h3F800000, 1'b0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      step(1'b1, da[i], db[i], ds[i], 1'b0);
      chk("spec_result", bus.result, dr[i]);
      chk("spec_exc", 32'(bus.Exception), 32'(de[i]));
    end
    step(1'b0, 32'h12345678, 32'h9ABCDEF0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a, b;
      int ea, eb;
      a = $urandom;
      b = $urandom;
      ea = int'($urandom_range(1, 254));
      eb = ea + int'($urandom_range(0, 60)) - 30;
      if (eb < 0) eb = 0;
      if (eb > 255) eb = 255;
      a[30:23] = ea[7:0];
      b[30:23] = eb[7:0];
      case ($urandom_range(0, 15))
        0: b = a;
        1: b[30:0] = a[30:0];
        2: a[30:23] = 8'hFF;
        3: b[30:23] = 8'h00;
        4: a[30:23] = 8'hFE;
        default: ;
      endcase
      step($urandom_range(0, 7) != 0, a, b, 1'($urandom), 1'b0);
    end
    step(1'b1, 32'h3F800000, 32'h40000000, 1'b0, 1'b1);
    step(1'b1, 32'h3F800000, 32'h40000000, 1'b0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
